// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_e    : FSM states (idle, iterating, result-valid pulse)
//   DIV_WIDTH  : default operand/result width
//   cnt_width  : iteration counter width for a given operand width
package div_pkg;

    localparam int unsigned DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Counter must index 0..w-1; keep at least one bit for degenerate widths.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int unsigned DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
// Ports:
//   rem_i     : partial remainder before this step
//   quo_i     : dividend/quotient shift register before this step
//   divisor_i : captured divisor
//   rem_o     : partial remainder after this step
//   quo_o     : shift register after this step (new quotient bit in LSB)
module div_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Bring the next dividend bit into the remainder, then try subtracting.
    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign trial   = shifted - {1'b0, divisor_i};

    always_comb begin
        rem_o = shifted[WIDTH-1:0];
        quo_o = {quo_i[WIDTH-2:0], 1'b0};
        // Non-negative trial: keep the difference and record a 1.
        // A shifted remainder that failed is always below the divisor, so its
        // top bit is zero and dropping it is lossless.
        if (!trial[WIDTH]) begin
            rem_o = trial[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/divider_seq.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Optional feature macro: DIV_ZERO_FAST_EN (divide-by-zero finishes in one cycle).
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   start     : request, accepted in idle or in the done cycle
//   dividend  : numerator, sampled on accepted start
//   divisor   : denominator, sampled on accepted start
//   busy      : high while iterating
//   done      : one-cycle pulse when results are valid
//   quotient  : result, held until the next op completes
//   remainder : result, held until the next op completes
//   div_zero  : high when the captured divisor was zero
module divider_seq
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [WIDTH-1:0]  work_rem_q;
    logic [WIDTH-1:0]  work_quo_q;
    logic [WIDTH-1:0]  divisor_q;
    logic [WIDTH-1:0]  quotient_q;
    logic [WIDTH-1:0]  remainder_q;
    logic              busy_q;
    logic              done_q;
    logic              div_zero_q;

    logic [WIDTH-1:0]  step_rem;
    logic [WIDTH-1:0]  step_quo;
    logic              divisor_is_zero;

    assign divisor_is_zero = (divisor == '0);

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_i     (work_rem_q),
        .quo_i     (work_quo_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            work_rem_q  <= '0;
            work_quo_q  <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (start) begin
                        divisor_q  <= divisor;
                        work_rem_q <= '0;
                        work_quo_q <= dividend;
                        cnt_q      <= '0;
                        div_zero_q <= divisor_is_zero;
`ifdef DIV_ZERO_FAST_EN
                        // Zero divisor: the iterations would only shift the
                        // dividend into the remainder, so publish that directly.
                        if (divisor_is_zero) begin
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                            state_q     <= StDone;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            state_q <= StRun;
                            busy_q  <= 1'b1;
                        end
`else
                        state_q <= StRun;
                        busy_q  <= 1'b1;
`endif
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    work_rem_q <= step_rem;
                    work_quo_q <= step_quo;
                    cnt_q      <= cnt_q + CntW'(1);
                    // Visible results change only once, on the final iteration.
                    if (cnt_q == CntLast) begin
                        quotient_q  <= step_quo;
                        remainder_q <= step_rem;
                        state_q     <= StDone;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_divider_seq.sv
// Directed bench for divider_seq with a result scoreboard.
module tb_divider_seq;

    localparam int unsigned W = 16;
`ifdef DIV_ZERO_FAST_EN
    localparam int ZeroLat = 1;
`else
    localparam int ZeroLat = 17;
`endif

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   t0    = 0;
    int   busy_n = 0;
    int   done_n = 0;

    divider_seq #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, tallying busy/done seen in the cycle being left.
    task automatic tick();
        if (busy === 1'b1) busy_n++;
        if (done === 1'b1) done_n++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Drive a one-cycle start; the current cycle becomes cycle 0 of the op.
    task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        exp_t e;
        if (push) begin
            e.q  = (b == 0) ? {W{1'b1}} : a / b;
            e.r  = (b == 0) ? a : a % b;
            e.dz = (b == 0);
            sb.push_back(e);
        end
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        t0       = cyc;
        busy_n   = 0;
        done_n   = 0;
        tick();
        start    = 1'b0;
        dividend = $urandom_range(0, 65535);
        divisor  = $urandom_range(0, 65535);
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        exp_t e;
        while (done !== 1'b1 && (cyc - t0) < 40) tick();
        check({tag, "_latency"}, cyc - t0, exp_lat);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_quotient"}, quotient, e.q);
            check({tag, "_remainder"}, remainder, e.r);
            check({tag, "_div_zero"}, div_zero, e.dz);
        end
    endtask

    initial begin
        logic [W-1:0] held_q;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_quotient", quotient, 16'h0);
        check("rst_remainder", remainder, 16'h0);
        check("rst_div_zero", div_zero, 1'b0);
        rst = 1'b0;
        tick();

        // 100 / 7 with cycle-accurate latency and busy width.
        pulse_start(16'd100, 16'd7, 1'b1);
        wait_done("t1", 17);
        check("t1_busy_cycles", busy_n, 16);
        check("t1_busy_in_done", busy, 1'b0);
        tick();
        check("t1_done_one_cycle", done, 1'b0);
        check("t1_hold_quotient", quotient, 16'd14);

        // Boundaries: max / 1 and small / large.
        pulse_start(16'hFFFF, 16'd1, 1'b1);
        wait_done("t2a", 17);
        tick();
        pulse_start(16'd5, 16'd9, 1'b1);
        wait_done("t2b", 17);
        tick();

        // Divide by zero.
        pulse_start(16'd1234, 16'd0, 1'b1);
        wait_done("t3", ZeroLat);
        check("t3_busy_cycles", busy_n, ZeroLat - 1);
        tick();
        tick();

        // start during RUN is ignored; results frozen mid-run.
        held_q = 16'hFFFF;
        pulse_start(16'd200, 16'd10, 1'b1);
        while ((cyc - t0) < 5) tick();
        check("t4_busy_mid", busy, 1'b1);
        check("t4_quotient_frozen", quotient, held_q);
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 16'd3;
        tick();
        start    = 1'b0;
        wait_done("t4", 17);
        for (int i = 0; i < 20; i++) tick();
        check("t4_single_done", done_n, 1);
        check("t4_sb_drained", sb.size(), 0);

        // Asynchronous reset mid-run.
        pulse_start(16'd999, 16'd7, 1'b0);
        while ((cyc - t0) < 8) tick();
        rst = 1'b1;
        #1;
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_done", done, 1'b0);
        check("t5_rst_quotient", quotient, 16'h0);
        check("t5_rst_remainder", remainder, 16'h0);
        check("t5_rst_div_zero", div_zero, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("t5_no_done", done_n, 0);
        pulse_start(16'd81, 16'd9, 1'b1);
        wait_done("t5", 17);
        tick();

        // Back-to-back: new start in the DONE cycle.
        pulse_start(16'd7, 16'd2, 1'b1);
        wait_done("t6a", 17);
        pulse_start(16'd60, 16'd4, 1'b1);
        check("t6_busy_after_b2b", busy, 1'b1);
        wait_done("t6b", 17);
        tick();
        check("t6_done_drop", done, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
